// File: rtl/ssb_pkg.sv
// Shared SSB geometry constants and the extractor state encoding.
package ssb_pkg;

  localparam int SSB_LEN    = 240;  // subcarriers in one SSB
  localparam int SSS_LEN    = 127;
  localparam int SSS_OFFSET = 56;   // first SSS subcarrier relative to SSB start
  localparam int SSS_SYMBOL = 2;    // SSB symbol index carrying the SSS

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYM,
    COUNT,
    EXTRACT
  } ssb_state_t;

endpackage

// File: rtl/ssb_sss_extractor.sv
// Picks the 127 SSS subcarriers out of SSB symbol 2 of an fft-shifted FFT stream
// and hands them, with the latched N_id_2, to the SSS detector.
module ssb_sss_extractor
  import ssb_pkg::*;
#(
  parameter int IN_DW   = 32,
  parameter int FFT_LEN = 256
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             s_axis_in_tlast,
  input  logic             ssb_start_i,
  input  logic [1:0]       N_id_2_i,
  output logic [IN_DW-1:0] m_axis_out_tdata,
  output logic             m_axis_out_tvalid,
  output logic             m_axis_out_tlast,
  output logic [1:0]       N_id_2_o,
  output logic             N_id_2_valid_o,
  output logic             err_o
);

  localparam int BIN_W     = $clog2(FFT_LEN);
  localparam int SSB_START = FFT_LEN / 2 - SSB_LEN / 2;

  localparam logic [BIN_W-1:0] WIN_LO     = BIN_W'(SSB_START + SSS_OFFSET);
  localparam logic [BIN_W-1:0] WIN_HI     = BIN_W'(SSB_START + SSS_OFFSET + SSS_LEN - 1);
  localparam logic [BIN_W-1:0] BIN_LAST   = BIN_W'(FFT_LEN - 1);
  localparam logic [1:0]       SYM_BEFORE = 2'(SSS_SYMBOL - 1);

  ssb_state_t       state, state_d;
  logic [BIN_W-1:0] bin_cnt;
  logic             in_sym, in_sym_d;
  logic [1:0]       sym_cnt, sym_cnt_d;
  logic             at_end, sym_end, frame_err, in_win;
  logic             valid_d, last_d, nid_valid_d, err_d;
  logic [1:0]       nid_d;

  // A symbol ends on tlast, or on the last bin when tlast went missing (resync).
  assign at_end    = (bin_cnt == BIN_LAST);
  assign sym_end   = s_axis_in_tlast || at_end;
  assign in_sym_d  = s_axis_in_tvalid ? !sym_end : in_sym;
  assign frame_err = (state != IDLE) && s_axis_in_tvalid && (s_axis_in_tlast != at_end);
  assign in_win    = (bin_cnt >= WIN_LO) && (bin_cnt <= WIN_HI);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bin_cnt <= '0;
      in_sym  <= 1'b0;
    end else if (s_axis_in_tvalid) begin
      bin_cnt <= sym_end ? '0 : bin_cnt + BIN_W'(1);
      in_sym  <= in_sym_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    sym_cnt_d   = sym_cnt;
    nid_d       = N_id_2_o;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    nid_valid_d = 1'b0;
    err_d       = 1'b0;

    if (ssb_start_i) begin
      // A start that lands inside a symbol must skip the rest of that symbol.
      nid_d     = N_id_2_i;
      sym_cnt_d = '0;
      state_d   = in_sym_d ? WAIT_SYM : COUNT;
    end else if (frame_err) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: ;
        WAIT_SYM: if (s_axis_in_tvalid && s_axis_in_tlast) state_d = COUNT;
        COUNT: begin
          if (s_axis_in_tvalid && s_axis_in_tlast) begin
            sym_cnt_d = sym_cnt + 2'd1;
            if (sym_cnt == SYM_BEFORE) begin
              nid_valid_d = 1'b1;
              state_d     = EXTRACT;
            end
          end
        end
        EXTRACT: begin
          if (s_axis_in_tvalid && in_win) begin
            valid_d = 1'b1;
            last_d  = (bin_cnt == WIN_HI);
          end
          if (s_axis_in_tvalid && s_axis_in_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state             <= IDLE;
      sym_cnt           <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tlast  <= 1'b0;
      N_id_2_o          <= '0;
      N_id_2_valid_o    <= 1'b0;
      err_o             <= 1'b0;
    end else begin
      state             <= state_d;
      sym_cnt           <= sym_cnt_d;
      m_axis_out_tvalid <= valid_d;
      m_axis_out_tlast  <= last_d;
      N_id_2_o          <= nid_d;
      N_id_2_valid_o    <= nid_valid_d;
      err_o             <= err_d;
      if (valid_d) m_axis_out_tdata <= s_axis_in_tdata;
    end
  end

endmodule

// File: tb/tb_ssb_sss_extractor.sv
// Scoreboard bench for ssb_sss_extractor: a symbol-level reference model queues
// expected samples, N_id_2 pulses and errors; a monitor pops them as they appear.
module tb_ssb_sss_extractor;

  localparam int IN_DW   = 32;
  localparam int FFT_LEN = 256;
  localparam int SSS_SYM = 2;
  localparam int WIN_LO  = FFT_LEN / 2 - 120 + 56;
  localparam int WIN_HI  = WIN_LO + 127 - 1;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic [IN_DW-1:0] s_axis_in_tdata;
  logic             s_axis_in_tvalid;
  logic             s_axis_in_tlast;
  logic             ssb_start_i;
  logic [1:0]       N_id_2_i;
  logic [IN_DW-1:0] m_axis_out_tdata;
  logic             m_axis_out_tvalid;
  logic             m_axis_out_tlast;
  logic [1:0]       N_id_2_o;
  logic             N_id_2_valid_o;
  logic             err_o;

  ssb_sss_extractor #(.IN_DW(IN_DW), .FFT_LEN(FFT_LEN)) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .s_axis_in_tlast   (s_axis_in_tlast),
    .ssb_start_i       (ssb_start_i),
    .N_id_2_i          (N_id_2_i),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .N_id_2_o          (N_id_2_o),
    .N_id_2_valid_o    (N_id_2_valid_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IN_DW-1:0] data;
    logic             last;
    logic [1:0]       nid;
  } exp_t;

  exp_t       out_q[$];
  logic [1:0] nid_q[$];
  int         err_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model: position in the current symbol and symbols seen since arming.
  int         pos = 0;
  bit         armed = 1'b0;
  bit         skip_partial = 1'b0;
  int         sym_idx = 0;
  logic [1:0] m_nid = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_cycle(input bit s, input logic [1:0] n, input bit v, input bit l,
                             input logic [IN_DW-1:0] d);
    bit at_end, ends, bad;
    at_end = (pos == FFT_LEN - 1);
    ends   = v && (l || at_end);
    bad    = v && (l != at_end);
    if (s) begin
      m_nid        = n;
      armed        = 1'b1;
      sym_idx      = 0;
      skip_partial = v ? !ends : (pos != 0);
    end else if (armed && bad) begin
      err_q.push_back(pos);
      armed = 1'b0;
    end else if (armed && v) begin
      if (skip_partial) begin
        if (ends) skip_partial = 1'b0;
      end else if (sym_idx == SSS_SYM) begin
        if (pos >= WIN_LO && pos <= WIN_HI) out_q.push_back('{d, logic'(pos == WIN_HI), m_nid});
        if (ends) armed = 1'b0;
      end else if (ends) begin
        sym_idx++;
        if (sym_idx == SSS_SYM) nid_q.push_back(m_nid);
      end
    end
    if (v) pos = ends ? 0 : pos + 1;
  endtask

  task automatic cycle(input bit v, input bit l, input logic [IN_DW-1:0] d,
                       input bit s, input logic [1:0] n);
    s_axis_in_tvalid = v;
    s_axis_in_tlast  = l;
    s_axis_in_tdata  = d;
    ssb_start_i      = s;
    N_id_2_i         = n;
    model_cycle(s, n, v, l, d);
    @(posedge clk_i);
    #1;
  endtask

  // One symbol of n_beats bins; optional tlast on the final beat, a start pulse
  // on bin start_bin (-1 = none), random idle gaps and bin-index or random data.
  task automatic send_sym(input int n_beats, input bit with_last, input int start_bin,
                          input logic [1:0] nid, input int gap_pct, input bit idx_data);
    logic [IN_DW-1:0] d;
    for (int b = 0; b < n_beats; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) cycle(1'b0, 1'b0, '0, 1'b0, nid);
      d = idx_data ? IN_DW'(b) : IN_DW'($urandom);
      cycle(1'b1, with_last && (b == n_beats - 1), d, b == start_bin, nid);
    end
  endtask

  task automatic start_idle(input logic [1:0] nid);
    cycle(1'b0, 1'b0, '0, 1'b0, nid);
    cycle(1'b0, 1'b0, '0, 1'b1, nid);
  endtask

  task automatic drain(input string name);
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b0, 2'd0);
    check({name, "_out_left"}, 64'(out_q.size()), 64'(0));
    check({name, "_nid_left"}, 64'(nid_q.size()), 64'(0));
    check({name, "_err_left"}, 64'(err_q.size()), 64'(0));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_tvalid"}, 64'(m_axis_out_tvalid), 64'(0));
    check({name, "_tlast"},  64'(m_axis_out_tlast),  64'(0));
    check({name, "_tdata"},  64'(m_axis_out_tdata),  64'(0));
    check({name, "_nid"},    64'(N_id_2_o),          64'(0));
    check({name, "_nidv"},   64'(N_id_2_valid_o),    64'(0));
    check({name, "_err"},    64'(err_o),             64'(0));
  endtask

  exp_t       mon_e;
  logic [1:0] mon_nid;

  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (m_axis_out_tvalid) begin
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual tdata=%0h tlast=%0b expected no output",
                   m_axis_out_tdata, m_axis_out_tlast);
        end else begin
          mon_e = out_q.pop_front();
          check("out_tdata", 64'(m_axis_out_tdata), 64'(mon_e.data));
          check("out_tlast", 64'(m_axis_out_tlast), 64'(mon_e.last));
          check("out_nid",   64'(N_id_2_o),         64'(mon_e.nid));
        end
      end
      if (N_id_2_valid_o) begin
        if (nid_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_nid_valid actual N_id_2_o=%0d expected no pulse", N_id_2_o);
        end else begin
          mon_nid = nid_q.pop_front();
          check("nid_value", 64'(N_id_2_o), 64'(mon_nid));
          check("nid_before_data", 64'(m_axis_out_tvalid), 64'(0));
        end
      end
      if (err_o) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err actual err_o=1 expected 0");
        end else begin
          void'(err_q.pop_front());
          checks++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ni         = 1'b0;
    s_axis_in_tdata  = '0;
    s_axis_in_tvalid = 1'b0;
    s_axis_in_tlast  = 1'b0;
    ssb_start_i      = 1'b0;
    N_id_2_i         = '0;
    #1;
    check_outputs_zero("reset");
    #20;
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: start between symbols, gapless, bin-index data
    start_idle(2'd2);
    repeat (4) send_sym(FFT_LEN, 1'b1, -1, 2'd2, 0, 1'b1);
    drain("t1");

    // 2: start mid-symbol at bin 100
    send_sym(FFT_LEN, 1'b1, 100, 2'd1, 0, 1'b1);
    repeat (4) send_sym(FFT_LEN, 1'b1, -1, 2'd1, 0, 1'b0);
    drain("t2");

    // 3: random tvalid gaps
    start_idle(2'd3);
    repeat (4) send_sym(FFT_LEN, 1'b1, -1, 2'd3, 30, 1'b1);
    drain("t3");

    // 4: early tlast at bin 200 in symbol 1, then a missing tlast, then recovery
    start_idle(2'd0);
    send_sym(FFT_LEN, 1'b1, -1, 2'd0, 0, 1'b0);
    send_sym(201, 1'b1, -1, 2'd0, 0, 1'b0);
    repeat (2) send_sym(FFT_LEN, 1'b1, -1, 2'd0, 0, 1'b0);
    start_idle(2'd1);
    send_sym(FFT_LEN, 1'b0, -1, 2'd1, 0, 1'b0);
    start_idle(2'd2);
    repeat (4) send_sym(FFT_LEN, 1'b1, -1, 2'd2, 0, 1'b0);
    drain("t4");

    // 5: re-arm during EXTRACT after 50 outputs
    start_idle(2'd2);
    repeat (2) send_sym(FFT_LEN, 1'b1, -1, 2'd2, 0, 1'b0);
    send_sym(FFT_LEN, 1'b1, WIN_LO + 50, 2'd3, 0, 1'b0);
    repeat (4) send_sym(FFT_LEN, 1'b1, -1, 2'd3, 0, 1'b0);
    drain("t5");

    // 7: start coincident with the tlast beat of a symbol
    send_sym(FFT_LEN, 1'b1, FFT_LEN - 1, 2'd1, 0, 1'b0);
    repeat (4) send_sym(FFT_LEN, 1'b1, -1, 2'd1, 0, 1'b0);
    drain("t7");

    // 6: asynchronous reset mid-EXTRACT, then no output without a new start
    start_idle(2'd3);
    repeat (2) send_sym(FFT_LEN, 1'b1, -1, 2'd3, 0, 1'b0);
    send_sym(130, 1'b0, -1, 2'd3, 0, 1'b0);
    #2;
    reset_ni         = 1'b0;
    s_axis_in_tvalid = 1'b0;
    s_axis_in_tlast  = 1'b0;
    ssb_start_i      = 1'b0;
    out_q.delete();
    nid_q.delete();
    err_q.delete();
    pos   = 0;
    armed = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (3) send_sym(FFT_LEN, 1'b1, -1, 2'd2, 0, 1'b0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
